// File: rtl/steer_pkg.sv
// Shared types and constants for the steer load-cell qualifier.
package steer_pkg;
  typedef logic [11:0] ld_t;
  typedef logic [12:0] sum_t;

  localparam sum_t MIN_RIDER_WT_DFLT = 13'h0200;
  localparam sum_t WT_HYST_DFLT      = 13'h0040;

  localparam logic [25:0] TMR_TERM_FULL = 26'd65_000_000;
  localparam logic [25:0] TMR_TERM_SIM  = 26'd1024;

  typedef struct packed {
    logic sum_gt_min;
    logic sum_lt_min;
    logic diff_gt_1_4;
    logic diff_gt_15_16;
  } flags_t;

  // A rider reads "absent" until the first valid sample arrives.
  localparam flags_t FLAGS_RST = '{sum_gt_min: 1'b0, sum_lt_min: 1'b1,
                                   diff_gt_1_4: 1'b0, diff_gt_15_16: 1'b0};
endpackage

// File: rtl/steer_ld_qual_if.sv
// A2D load-cell sample bus: one-cycle vld strobe with left/right readings.
interface steer_ld_qual_if;
  import steer_pkg::*;
  logic vld;
  ld_t  lft_ld;
  ld_t  rght_ld;

  modport master (output vld, lft_ld, rght_ld);
  modport slave  (input  vld, lft_ld, rght_ld);
endinterface

// File: rtl/steer_tmr.sv
// Saturating stabilise timer; terminal count chosen by FAST_SIM.
module steer_tmr
  import steer_pkg::*;
#(
  parameter bit FAST_SIM = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_tmr,
  output logic tmr_full
);
  localparam logic [25:0] TERM = FAST_SIM ? TMR_TERM_SIM : TMR_TERM_FULL;
  localparam logic [25:0] LAST = TERM - 26'd1;

  logic [25:0] cnt;

  // Full flag compares the current count, so it rises one edge after cnt hits LAST,
  // giving exactly TERM cycles from the clearing edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      tmr_full <= 1'b0;
    end else if (clr_tmr) begin
      cnt      <= '0;
      tmr_full <= 1'b0;
    end else begin
      if (cnt != LAST) cnt <= cnt + 26'd1;
      tmr_full <= (cnt == LAST);
    end
  end
endmodule

// File: rtl/steer_ld_qual.sv
// Load-cell qualifier: sample capture, sum/|diff| flags and stabilise timer.
// Optional LD_AVG_EN: flags use a 4-deep per-channel moving average.
module steer_ld_qual
  import steer_pkg::*;
#(
  parameter bit   FAST_SIM     = 1'b0,
  parameter sum_t MIN_RIDER_WT = MIN_RIDER_WT_DFLT,
  parameter sum_t WT_HYST      = WT_HYST_DFLT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  steer_ld_qual_if.slave        ld,
  input  logic                  clr_tmr,
  output logic                  tmr_full,
  output logic                  sum_gt_min,
  output logic                  sum_lt_min,
  output logic                  diff_gt_1_4,
  output logic                  diff_gt_15_16
);
  localparam sum_t WT_HI = MIN_RIDER_WT + WT_HYST;
  localparam sum_t WT_LO = MIN_RIDER_WT - WT_HYST;

  ld_t lft_s, rght_s;

`ifdef LD_AVG_EN
  logic [3:0][11:0] lft_h, rght_h;
  logic [13:0]      lft_acc, rght_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lft_h  <= '0;
      rght_h <= '0;
    end else if (ld.vld) begin
      lft_h  <= {lft_h[2:0], ld.lft_ld};
      rght_h <= {rght_h[2:0], ld.rght_ld};
    end
  end

  always_comb begin
    lft_acc  = 14'(lft_h[0])  + 14'(lft_h[1])  + 14'(lft_h[2])  + 14'(lft_h[3]);
    rght_acc = 14'(rght_h[0]) + 14'(rght_h[1]) + 14'(rght_h[2]) + 14'(rght_h[3]);
  end

  assign lft_s  = ld_t'(lft_acc >> 2);
  assign rght_s = ld_t'(rght_acc >> 2);
`else
  ld_t lft_q, rght_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lft_q  <= '0;
      rght_q <= '0;
    end else if (ld.vld) begin
      lft_q  <= ld.lft_ld;
      rght_q <= ld.rght_ld;
    end
  end

  assign lft_s  = lft_q;
  assign rght_s = rght_q;
`endif

  sum_t   sum_c, dsub;
  ld_t    diff_c;
  flags_t flg_d, flg_q;

  always_comb begin
    sum_c  = {1'b0, lft_s} + {1'b0, rght_s};
    dsub   = {1'b0, lft_s} - {1'b0, rght_s};
    // Borrow out means rght > lft; redo the subtraction the other way round.
    diff_c = dsub[12] ? (rght_s - lft_s) : dsub[11:0];
    flg_d               = FLAGS_RST;
    flg_d.sum_gt_min    = sum_c > WT_HI;
    flg_d.sum_lt_min    = sum_c < WT_LO;
    flg_d.diff_gt_1_4   = {1'b0, diff_c} > (sum_c >> 2);
    flg_d.diff_gt_15_16 = {1'b0, diff_c} > (sum_c - (sum_c >> 4));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flg_q <= FLAGS_RST;
    else        flg_q <= flg_d;
  end

  assign sum_gt_min    = flg_q.sum_gt_min;
  assign sum_lt_min    = flg_q.sum_lt_min;
  assign diff_gt_1_4   = flg_q.diff_gt_1_4;
  assign diff_gt_15_16 = flg_q.diff_gt_15_16;

  steer_tmr #(.FAST_SIM(FAST_SIM)) u_tmr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_tmr  (clr_tmr),
    .tmr_full (tmr_full)
  );
endmodule

// File: tb/tb_steer_ld_qual.sv
// Self-checking bench for steer_ld_qual: flag vectors, timer, async reset.
module tb_steer_ld_qual;
  logic clk = 1'b0;
  logic rst_n;
  logic clr_tmr;
  logic tmr_full, sum_gt_min, sum_lt_min, diff_gt_1_4, diff_gt_15_16;

  steer_ld_qual_if ld_if ();

  steer_ld_qual #(.FAST_SIM(1'b1)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ld            (ld_if),
    .clr_tmr       (clr_tmr),
    .tmr_full      (tmr_full),
    .sum_gt_min    (sum_gt_min),
    .sum_lt_min    (sum_lt_min),
    .diff_gt_1_4   (diff_gt_1_4),
    .diff_gt_15_16 (diff_gt_15_16)
  );

  always #10 clk = ~clk;

  // {gt_min, lt_min, diff_gt_1_4, diff_gt_15_16}
  logic [3:0] act_flags;
  assign act_flags = {sum_gt_min, sum_lt_min, diff_gt_1_4, diff_gt_15_16};

  int n_pass = 0;
  int n_total = 0;

  logic [3:0] sb_exp[$];
  string      sb_nm[$];

  typedef struct {
    logic [11:0] l;
    logic [11:0] r;
    logic [3:0]  exp;
    string       nm;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Strobe one sample, queue its expected flags, compare two cycles later.
  task automatic apply(input logic [11:0] l, input logic [11:0] r,
                       input logic [3:0] e, input string nm);
    @(negedge clk);
    ld_if.vld = 1'b1; ld_if.lft_ld = l; ld_if.rght_ld = r;
    sb_exp.push_back(e); sb_nm.push_back(nm);
    @(negedge clk);
    ld_if.vld = 1'b0; ld_if.lft_ld = 12'($urandom); ld_if.rght_ld = 12'($urandom);
    @(negedge clk);
    chk(sb_nm.pop_front(), {28'd0, act_flags}, {28'd0, sb_exp.pop_front()});
  endtask

  task automatic measure(output int n);
    n = 0;
    for (int k = 1; k <= 2000; k++) begin
      @(posedge clk); @(negedge clk);
      if (tmr_full) begin n = k; break; end
    end
  endtask

  vec_t vecs[17];
  int   n;

  initial begin
    vecs[0]  = '{12'h180, 12'h180, 4'b1000, "centred"};
    vecs[1]  = '{12'h300, 12'h100, 4'b1010, "off_ctr"};
    vecs[2]  = '{12'h3F0, 12'h010, 4'b1011, "step_off"};
    vecs[3]  = '{12'h010, 12'h3F0, 4'b1011, "step_off_swap"};
    vecs[4]  = '{12'h100, 12'h100, 4'b0000, "hyst_mid"};
    vecs[5]  = '{12'h080, 12'h080, 4'b0100, "sum_low"};
    vecs[6]  = '{12'h141, 12'h100, 4'b1000, "sum_241"};
    vecs[7]  = '{12'h140, 12'h100, 4'b0000, "sum_240"};
    vecs[8]  = '{12'h000, 12'h000, 4'b0100, "sum_zero"};
    vecs[9]  = '{12'h1BF, 12'h000, 4'b0111, "sum_1bf"};
    vecs[10] = '{12'h1C0, 12'h000, 4'b0011, "sum_1c0"};
    vecs[11] = '{12'hFFF, 12'hFFF, 4'b1000, "max_both"};
    vecs[12] = '{12'hFFF, 12'h000, 4'b1011, "max_one"};
    vecs[13] = '{12'h140, 12'h0C0, 4'b0000, "q_edge_eq"};
    vecs[14] = '{12'h141, 12'h0C0, 4'b0010, "q_edge_gt"};
    vecs[15] = '{12'h3E0, 12'h020, 4'b1010, "s16_edge_eq"};
    vecs[16] = '{12'h3E1, 12'h01F, 4'b1011, "s16_edge_gt"};

    rst_n = 1'b0; clr_tmr = 1'b0;
    ld_if.vld = 1'b0; ld_if.lft_ld = '0; ld_if.rght_ld = '0;
    repeat (3) @(negedge clk);
    chk("rst_flags", {28'd0, act_flags}, 32'h4);
    chk("rst_tmr", {31'd0, tmr_full}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_flags", {28'd0, act_flags}, 32'h4);

`ifndef LD_AVG_EN
    foreach (vecs[i]) apply(vecs[i].l, vecs[i].r, vecs[i].exp, vecs[i].nm);
    repeat (5) @(negedge clk);
    chk("flags_hold", {28'd0, act_flags}, 32'hB);
`endif

    // Timer: clear, release, expect terminal count to the cycle.
    @(negedge clk); clr_tmr = 1'b1;
    @(negedge clk); clr_tmr = 1'b0;
    chk("tmr_clr", {31'd0, tmr_full}, 32'd0);
    measure(n);
    chk("tmr_latency", n, 1024);
    repeat (10) @(negedge clk);
    chk("tmr_hold", {31'd0, tmr_full}, 32'd1);
    clr_tmr = 1'b1;
    @(negedge clk);
    chk("tmr_clr_full", {31'd0, tmr_full}, 32'd0);
    clr_tmr = 1'b0;
    measure(n);
    chk("tmr_latency2", n, 1024);

`ifndef LD_AVG_EN
    apply(12'h3F0, 12'h010, 4'b1011, "pre_rst");
`endif
    // Async reset between edges: outputs must drop without a clock.
    @(negedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_flags", {28'd0, act_flags}, 32'h4);
    chk("async_rst_tmr", {31'd0, tmr_full}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_samples_cleared", {28'd0, act_flags}, 32'h4);

`ifdef LD_AVG_EN
    apply(12'h200, 12'h000, 4'b0111, "avg1");
    apply(12'h200, 12'h000, 4'b0111, "avg2");
    apply(12'h200, 12'h000, 4'b0111, "avg3");
    apply(12'h200, 12'h000, 4'b0011, "avg4");
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
